uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: OVERSAMPLE, 16, sample ticks per bit period.
REQ-002 Parameter: DATA_BITS, 8, data bits per frame.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 rxd  input  1  asynchronous serial line; idle high.
REQ-007 rx_en  input  1  oversample baud enable; each rising edge is one tick.
REQ-008 iocs  input  1  I/O chip select.
REQ-009 iorw  input  1  1 = processor read.
REQ-010 ioaddr  input  2  register select; 2'b00 = receive buffer.
REQ-011 receive_buffer  output  8  last good received byte.
REQ-012 rda  output  1  receive data available.
REQ-013 framing_err  output  1  last frame had stop bit = 0.
REQ-014 overrun  output  1  unread byte was overwritten.

Function
REQ-015 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 Tick SHALL be a single-cycle pulse on the registered rising edge of rx_en; a held-high rx_en gives exactly one tick.
REQ-017 Read strobe SHALL be iocs & iorw & (ioaddr == 2'b00).
REQ-018 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-019 IDLE: on a tick with synced rxd = 0 -> START; clear the tick counter.
REQ-020 START: at tick count OVERSAMPLE/2-1 (7), rxd = 0 -> DATA with counter and bit count cleared; rxd = 1 -> IDLE (glitch rejected).
REQ-021 DATA: every OVERSAMPLE ticks (mid-bit), shift rxd into bit DATA_BITS-1 of the shift register, shifting right (LSB first); after DATA_BITS samples -> STOP.
REQ-022 STOP: at the OVERSAMPLE-th tick, sample rxd and go to IDLE.
REQ-023 Good stop (rxd = 1): load receive_buffer from the shift register, set rda = 1, clear framing_err; rda rises one clk after the stop sample tick.
REQ-024 Bad stop (rxd = 0): set framing_err = 1; receive_buffer and rda unchanged.
REQ-025 A good load while rda = 1 and no read strobe in the same cycle SHALL set overrun = 1 and overwrite receive_buffer.
REQ-026 Read strobe SHALL clear rda and overrun on the next clk; receive_buffer holds its value.
REQ-027 Load and read strobe in the same cycle: load wins; rda = 1, overrun = 0.
REQ-028 Tick counter and bit counter widths SHALL be clog2 of their terminal counts; neither SHALL wrap within a frame.
REQ-029 rx_en is ignored outside ticks; no state advances without a tick.

Reset
REQ-030 rst = 0 at a clk edge SHALL force: FSM to IDLE, counters 0, shift register 0, receive_buffer 8'h00, rda 0, framing_err 0, overrun 0, synchronizer flops 1.
REQ-031 Reset mid-frame SHALL abandon the frame with no load; reception resumes at the next falling edge after release.

Structure
REQ-032 FSM state encodings, OVERSAMPLE, DATA_BITS and the receive-buffer ioaddr SHALL live in a shared UART package used by both uart_rx and the transmitter.
REQ-033 The shift/load datapath SHALL be one sub-module, rx_shift_reg; the rising-edge detector SHALL be the existing shared edge-detect block.

Verification
REQ-034 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) at 16 ticks/bit -> receive_buffer = 8'hA5, rda = 1, framing_err = 0.
REQ-035 rxd low for 3 ticks, then high -> FSM back to IDLE at tick 7; rda = 0; a following 0x3C frame is received correctly.
REQ-036 Frame 0x55 with stop bit 0 -> framing_err = 1, rda = 0, receive_buffer unchanged.
REQ-037 Frames 0x11 and 0x22 with no read -> receive_buffer = 8'h22, rda = 1, overrun = 1; read strobe -> rda = 0, overrun = 0.
REQ-038 Read strobe in the exact load cycle of 0x7E -> rda = 1, overrun = 0, receive_buffer = 8'h7E.
REQ-039 rst = 0 during data bit 4 of a frame -> all outputs 0 next clk; next full frame 0x81 -> receive_buffer = 8'h81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, register map and receiver FSM encoding.
// Used by uart_rx and by the matching transmitter.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  localparam logic [1:0] RX_BUF_ADDR = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Per-cycle datapath controls decoded from the receiver FSM.
  typedef struct packed {
    logic cnt_clr;
    logic cnt_inc;
    logic bit_clr;
    logic bit_inc;
    logic shift;
    logic load;
    logic bad;
  } rx_ctrl_t;

endpackage

// File: rtl/uart_rx_if.sv
// Processor-side register port of the UART receiver.
interface uart_rx_if #(
  parameter int DATA_BITS = uart_pkg::DATA_BITS
);
  logic                 iocs;
  logic                 iorw;
  logic [1:0]           ioaddr;
  logic [DATA_BITS-1:0] receive_buffer;
  logic                 rda;
  logic                 framing_err;
  logic                 overrun;

  modport master (
    output iocs, iorw, ioaddr,
    input  receive_buffer, rda, framing_err, overrun
  );

  modport slave (
    input  iocs, iorw, ioaddr,
    output receive_buffer, rda, framing_err, overrun
  );
endinterface

// File: rtl/edge_detect.sv
// Shared rising-edge detector: one registered pulse per low-to-high transition,
// so a level held high produces a single pulse.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise
);
  logic r_prev;
  logic r_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_sig;
      r_rise <= i_sig & ~r_prev;
    end
  end

  assign o_rise = r_rise;
endmodule

// File: rtl/rx_shift_reg.sv
// Receive datapath: LSB-first shift register, receive buffer and status flags
// (data available, framing error, overrun) with processor read clearing.
module rx_shift_reg #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_shift,
  input  logic                 i_bit,
  input  logic                 i_load,
  input  logic                 i_bad,
  input  logic                 i_rd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rda,
  output logic                 o_ferr,
  output logic                 o_overrun
);
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_buf;
  logic                 r_rda;
  logic                 r_ferr;
  logic                 r_overrun;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift   <= '0;
      r_buf     <= '0;
      r_rda     <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_shift)
        r_shift <= {i_bit, r_shift[DATA_BITS-1:1]};

      // A load beats a simultaneous read: the fresh byte stays available.
      if (i_load) begin
        r_buf     <= r_shift;
        r_rda     <= 1'b1;
        r_ferr    <= 1'b0;
        r_overrun <= ~i_rd & (r_overrun | r_rda);
      end else begin
        if (i_bad)
          r_ferr <= 1'b1;
        if (i_rd) begin
          r_rda     <= 1'b0;
          r_overrun <= 1'b0;
        end
      end
    end
  end

  assign o_data    = r_buf;
  assign o_rda     = r_rda;
  assign o_ferr    = r_ferr;
  assign o_overrun = r_overrun;
endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronizes rxd, finds the start bit mid-point
// on rx_en ticks and samples each data and stop bit at its centre.
module uart_rx #(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int DATA_BITS  = uart_pkg::DATA_BITS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rxd,
  input  logic     rx_en,
  uart_rx_if.slave bus
);
  import uart_pkg::*;

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic              r_rxd_meta;
  logic              r_rxd_sync;
  uart_state_e       r_state;
  uart_state_e       w_state_next;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              w_tick;
  logic              w_rd;
  logic              w_at_mid;
  logic              w_at_last;
  logic              w_bit_last;
  rx_ctrl_t          w_ctrl;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; blocking would collapse the two synchronizer stages into one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  edge_detect u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (rx_en),
    .o_rise (w_tick)
  );

  assign w_rd       = bus.iocs & bus.iorw & (bus.ioaddr == RX_BUF_ADDR);
  assign w_at_mid   = (r_tick_cnt == TICK_MID);
  assign w_at_last  = (r_tick_cnt == TICK_LAST);
  assign w_bit_last = (r_bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // NOTE: every always_comb assigns its outputs a default first, so no path leaves a latch behind.
  always_comb begin
    w_state_next = r_state;
    if (w_tick) begin
      unique case (r_state)
        ST_IDLE:  if (!r_rxd_sync) w_state_next = ST_START;
        ST_START: if (w_at_mid) w_state_next = r_rxd_sync ? ST_IDLE : ST_DATA;
        ST_DATA:  if (w_at_last && w_bit_last) w_state_next = ST_STOP;
        ST_STOP:  if (w_at_last) w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ctrl = '0;
    if (w_tick) begin
      unique case (r_state)
        ST_IDLE:  w_ctrl.cnt_clr = ~r_rxd_sync;
        ST_START: begin
          w_ctrl.cnt_clr = w_at_mid;
          w_ctrl.bit_clr = w_at_mid;
          w_ctrl.cnt_inc = ~w_at_mid;
        end
        ST_DATA: begin
          w_ctrl.cnt_clr = w_at_last;
          w_ctrl.shift   = w_at_last;
          w_ctrl.bit_inc = w_at_last & ~w_bit_last;
          w_ctrl.cnt_inc = ~w_at_last;
        end
        ST_STOP: begin
          w_ctrl.cnt_clr = w_at_last;
          w_ctrl.load    = w_at_last & r_rxd_sync;
          w_ctrl.bad     = w_at_last & ~r_rxd_sync;
          w_ctrl.cnt_inc = ~w_at_last;
        end
      endcase
    end
  end

  // Counters stop at their terminal values and are cleared there, never wrapped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_ctrl.cnt_clr)      r_tick_cnt <= '0;
      else if (w_ctrl.cnt_inc) r_tick_cnt <= r_tick_cnt + 1'b1;

      if (w_ctrl.bit_clr)      r_bit_cnt <= '0;
      else if (w_ctrl.bit_inc) r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  rx_shift_reg #(
    .DATA_BITS (DATA_BITS)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .i_shift   (w_ctrl.shift),
    .i_bit     (r_rxd_sync),
    .i_load    (w_ctrl.load),
    .i_bad     (w_ctrl.bad),
    .i_rd      (w_rd),
    .o_data    (bus.receive_buffer),
    .o_rda     (bus.rda),
    .o_ferr    (bus.framing_err),
    .o_overrun (bus.overrun)
  );
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of whole frames, hand-written corner
// sequences and random frames scored against a frame-level status model.
module tb_uart_rx;

  localparam int TICKS_PER_BIT = 16;
  localparam int FRAME_TICKS   = 10 * TICKS_PER_BIT;
  // Start centre is 8 ticks in; stop centre is nine bit periods later.
  localparam int STOP_TICK     = 8 + 9 * TICKS_PER_BIT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rxd = 1'b1;
  logic rx_en = 1'b0;

  uart_rx_if bus_if ();

  uart_rx dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rx_en (rx_en),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_buf;
  logic       m_rda;
  logic       m_ferr;
  logic       m_ovr;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         rd_after;
    int         hold;
    logic [7:0] e_buf;
    logic       e_rda;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] e_buf,
                               input logic e_rda, input logic e_ferr, input logic e_ovr);
    check({tag, ".receive_buffer"}, 32'(bus_if.receive_buffer), 32'(e_buf));
    check({tag, ".rda"},            32'(bus_if.rda),            32'(e_rda));
    check({tag, ".framing_err"},    32'(bus_if.framing_err),    32'(e_ferr));
    check({tag, ".overrun"},        32'(bus_if.overrun),        32'(e_ovr));
  endtask

  task automatic check_model(input string tag);
    check_outputs(tag, m_buf, m_rda, m_ferr, m_ovr);
  endtask

  task automatic model_reset();
    m_buf = 8'h00; m_rda = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] data, input logic stop, input bit rd_at_load);
    if (stop) begin
      m_ovr  = !rd_at_load && (m_ovr || m_rda);
      m_buf  = data;
      m_rda  = 1'b1;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic model_read();
    m_rda = 1'b0;
    m_ovr = 1'b0;
  endtask

  function automatic logic line_level(input logic [7:0] data, input logic stop, input int i);
    int slot;
    slot = i / TICKS_PER_BIT;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return data[slot-1];
    if (slot == 9) return stop;
    return 1'b1;
  endfunction

  // Drive one oversample tick: line settles through the synchronizer, then
  // rx_en is held high for 'hold' clocks; optional read strobe in the tick cycle.
  task automatic send_tick(input logic v, input int hold, input bit rd);
    rxd = v;
    repeat (3) @(negedge clk);
    rx_en = 1'b1;
    @(negedge clk);
    if (rd) begin
      bus_if.iocs = 1'b1; bus_if.iorw = 1'b1; bus_if.ioaddr = 2'b00;
    end
    if (hold == 1) rx_en = 1'b0;
    @(negedge clk);
    bus_if.iocs = 1'b0; bus_if.iorw = 1'b0;
    if (hold > 1) begin
      repeat (hold - 2) @(negedge clk);
      rx_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n, input int hold);
    repeat (n) send_tick(1'b1, hold, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int hold,
                            input bit rd_at_load, input bit chk_timing, input int n_ticks);
    idle(2, hold);
    for (int i = 0; i < n_ticks; i++) begin
      if (chk_timing && i == STOP_TICK) check("rda_before_stop_tick", 32'(bus_if.rda), 32'd0);
      send_tick(line_level(data, stop, i), hold, rd_at_load && (i == STOP_TICK));
      if (chk_timing && i == STOP_TICK) check("rda_after_stop_tick", 32'(bus_if.rda), 32'd1);
    end
    if (n_ticks == FRAME_TICKS) idle(10, hold);
  endtask

  task automatic do_read(input logic [1:0] addr, input logic cs, input logic rw);
    bus_if.iocs = cs; bus_if.iorw = rw; bus_if.ioaddr = addr;
    @(negedge clk);
    bus_if.iocs = 1'b0; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] r_data;
    logic       r_stop;
    bit         r_rd;
    int         r_hold;

    bus_if.iocs = 1'b0; bus_if.iorw = 1'b0; bus_if.ioaddr = 2'b00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    model_reset();
    rst = 1'b1;
    @(negedge clk);

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h55, 1'b0, 1'b0, 1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h11, 1'b1, 1'b0, 1, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h22, 1'b1, 1'b1, 1, 8'h22, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'hC3, 1'b1, 1'b0, 6, 8'hC3, 1'b1, 1'b0, 1'b0};

    for (int k = 0; k < 5; k++) begin
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].hold, 1'b0, 1'b0, FRAME_TICKS);
      model_frame(vecs[k].data, vecs[k].stop, 1'b0);
      check_outputs($sformatf("vec%0d", k), vecs[k].e_buf, vecs[k].e_rda,
                    vecs[k].e_ferr, vecs[k].e_ovr);
      if (vecs[k].rd_after) begin
        do_read(2'b00, 1'b1, 1'b1);
        model_read();
        check_outputs($sformatf("vec%0d_read", k), vecs[k].e_buf, 1'b0, vecs[k].e_ferr, 1'b0);
      end
    end

    // Exact load timing on a clean 0xA5 frame.
    do_read(2'b00, 1'b1, 1'b1);
    model_read();
    send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b1, FRAME_TICKS);
    model_frame(8'hA5, 1'b1, 1'b0);
    check_model("a5_timed");

    // Only cs & rw & address 0 is a read.
    do_read(2'b01, 1'b1, 1'b1);
    check_model("rd_wrong_addr");
    do_read(2'b00, 1'b1, 1'b0);
    check_model("rd_write_cycle");
    do_read(2'b00, 1'b0, 1'b1);
    check_model("rd_no_cs");
    do_read(2'b00, 1'b1, 1'b1);
    model_read();
    check_model("rd_real");

    // Three-tick glitch is rejected, then a real frame follows.
    idle(2, 1);
    repeat (3) send_tick(1'b0, 1, 1'b0);
    idle(20, 1);
    check_model("glitch");
    send_frame(8'h3C, 1'b1, 1, 1'b0, 1'b0, FRAME_TICKS);
    model_frame(8'h3C, 1'b1, 1'b0);
    check_model("after_glitch_3c");

    // Read strobe in the load cycle: load wins, no overrun.
    send_frame(8'h66, 1'b1, 1, 1'b0, 1'b0, FRAME_TICKS);
    model_frame(8'h66, 1'b1, 1'b0);
    check_model("pre_7e_66");
    send_frame(8'h7E, 1'b1, 1, 1'b1, 1'b0, FRAME_TICKS);
    model_frame(8'h7E, 1'b1, 1'b1);
    check_model("rd_in_load_7e");

    // Build overrun + framing error, then reset during data bit 4.
    send_frame(8'h99, 1'b1, 1, 1'b0, 1'b0, FRAME_TICKS);
    model_frame(8'h99, 1'b1, 1'b0);
    send_frame(8'h55, 1'b0, 1, 1'b0, 1'b0, FRAME_TICKS);
    model_frame(8'h55, 1'b0, 1'b0);
    check_model("pre_reset");
    send_frame(8'hF0, 1'b1, 1, 1'b0, 1'b0, 5 * TICKS_PER_BIT + 8);
    rst = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    model_reset();
    check_model("reset_midframe");
    rst = 1'b1;
    idle(5, 1);
    send_frame(8'h81, 1'b1, 1, 1'b0, 1'b0, FRAME_TICKS);
    model_frame(8'h81, 1'b1, 1'b0);
    check_model("after_reset_81");

    for (int n = 0; n < 16; n++) begin
      r_data = 8'($urandom_range(0, 255));
      r_stop = ($urandom_range(0, 3) != 0);
      r_rd   = 1'($urandom_range(0, 1));
      r_hold = $urandom_range(1, 3);
      send_frame(r_data, r_stop, r_hold, 1'b0, 1'b0, FRAME_TICKS);
      model_frame(r_data, r_stop, 1'b0);
      check_model($sformatf("rand%0d", n));
      if (r_rd) begin
        do_read(2'b00, 1'b1, 1'b1);
        model_read();
        check_model($sformatf("rand%0d_read", n));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
